// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
interface fp_mult_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 26
);
  logic             in_valid;
  logic             in_ready;
  logic             sign_A;
  logic             sign_B;
  logic [EXP_W-1:0] exp_A;
  logic [EXP_W-1:0] exp_B;
  logic [MAN_W-1:0] mantis_A;
  logic [MAN_W-1:0] mantis_B;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] mantis;
  logic             ovf;
  logic             unf;

  // Producer side: drives operands, consumes results.
  modport master (
    output in_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, out_ready,
    input  in_ready, out_valid, sign, exp, mantis, ovf, unf
  );

  // Multiplier side.
  modport slave (
    input  in_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, out_ready,
    output in_ready, out_valid, sign, exp, mantis, ovf, unf
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control, normalisation, optional round-to-nearest-even and range flags.
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 26,
  parameter int unsigned ROUND = 1
) (
  input logic           clk,
  input logic           rst,
  fp_mult_pipe_if.slave bus
);

  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned PW   = 2 * MAN_W;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  // Whole pipeline moves together; it only stalls when the output is blocked.
  logic adv_c;
  assign adv_c        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv_c;

  // ---------------- Stage 1 registers ----------------
  logic             s1_valid;
  logic             s1_sign;
  logic             s1_zero;
  logic [EXP_W-1:0] s1_ea;
  logic [EXP_W-1:0] s1_eb;
  logic [MAN_W-1:0] s1_ma;
  logic [MAN_W-1:0] s1_mb;

  // Capture operands and flag a zero operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else if (adv_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.sign_A ^ bus.sign_B;
        s1_zero <= (bus.exp_A == '0) | (bus.exp_B == '0);
        s1_ea   <= bus.exp_A;
        s1_eb   <= bus.exp_B;
        s1_ma   <= bus.mantis_A;
        s1_mb   <= bus.mantis_B;
      end
    end
  end

  // ---------------- Stage 2 ----------------
  logic [PW-1:0]        prod_c;
  logic signed [EW-1:0] exp_sum_c;

  // Full-width mantissa product and unbiased exponent sum.
  always_comb begin
    prod_c    = PW'(s1_ma) * PW'(s1_mb);
    exp_sum_c = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - $signed(EW'(BIAS));
  end

  logic                 s2_valid;
  logic                 s2_sign;
  logic                 s2_zero;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;

  // Register product and exponent sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_prod  <= '0;
      s2_exp   <= '0;
    end else if (adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_prod <= prod_c;
        s2_exp  <= exp_sum_c;
      end
    end
  end

  // ---------------- Stage 3 ----------------
  logic [PW-1:0]        norm_c;
  logic [MAN_W-1:0]     man_c;
  logic                 guard_c;
  logic                 sticky_c;
  logic                 round_up_c;
  logic                 carry_c;
  logic [MAN_W-1:0]     man_r_c;
  logic signed [EW-1:0] exp_n_c;
  logic signed [EW-1:0] exp_r_c;
  logic [EXP_W-1:0]     res_exp_c;
  logic [MAN_W-1:0]     res_man_c;
  logic                 res_ovf_c;
  logic                 res_unf_c;

  // Normalise, round, then range-check the final exponent.
  always_comb begin
    norm_c     = '0;
    man_c      = '0;
    guard_c    = 1'b0;
    sticky_c   = 1'b0;
    round_up_c = 1'b0;
    carry_c    = 1'b0;
    man_r_c    = '0;
    exp_n_c    = '0;
    exp_r_c    = '0;
    res_exp_c  = '0;
    res_man_c  = '0;
    res_ovf_c  = 1'b0;
    res_unf_c  = 1'b0;

    // Shift a product in [1,2) up one place so the leading one is always at the top.
    if (s2_prod[PW-1]) begin
      norm_c  = s2_prod;
      exp_n_c = s2_exp + $signed(EW'(1));
    end else begin
      norm_c  = {s2_prod[PW-2:0], 1'b0};
      exp_n_c = s2_exp;
    end

    man_c    = norm_c[PW-1 -: MAN_W];
    guard_c  = norm_c[MAN_W-1];
    sticky_c = |norm_c[MAN_W-2:0];

    round_up_c          = (ROUND == 1) && guard_c && (sticky_c || man_c[0]);
    {carry_c, man_r_c}  = {1'b0, man_c} + (MAN_W + 1)'(round_up_c);
    exp_r_c             = exp_n_c;
    if (carry_c) begin
      man_r_c = {1'b1, {(MAN_W - 1){1'b0}}};
      exp_r_c = exp_n_c + $signed(EW'(1));
    end

    if (s2_zero) begin
      res_exp_c = '0;
      res_man_c = '0;
    end else if (exp_r_c >= $signed(EW'(EMAX))) begin
      res_exp_c = '1;
      res_man_c = '0;
      res_ovf_c = 1'b1;
    end else if (exp_r_c <= $signed(EW'(0))) begin
      res_exp_c = '0;
      res_man_c = '0;
      res_unf_c = 1'b1;
    end else begin
      res_exp_c = exp_r_c[EXP_W-1:0];
      res_man_c = man_r_c;
    end
  end

  // Output register; holds while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sign      <= 1'b0;
      bus.exp       <= '0;
      bus.mantis    <= '0;
      bus.ovf       <= 1'b0;
      bus.unf       <= 1'b0;
    end else if (adv_c) begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.sign   <= s2_sign;
        bus.exp    <= res_exp_c;
        bus.mantis <= res_man_c;
        bus.ovf    <= res_ovf_c;
        bus.unf    <= res_unf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench: default-size multiplier in both rounding modes plus a
// narrow 4/4 instance for exponent-boundary and rounding-carry cases.
module tb_fp_mult_pipe;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(26)) bus_rne ();
  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(26)) bus_trn ();
  fp_mult_pipe_if #(.EXP_W(4), .MAN_W(4))  bus_sml ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(26), .ROUND(1)) dut_rne (.clk(clk), .rst(rst), .bus(bus_rne));
  fp_mult_pipe #(.EXP_W(8), .MAN_W(26), .ROUND(0)) dut_trn (.clk(clk), .rst(rst), .bus(bus_trn));
  fp_mult_pipe #(.EXP_W(4), .MAN_W(4),  .ROUND(1)) dut_sml (.clk(clk), .rst(rst), .bus(bus_sml));

  int passed;
  int total;

  // Count one comparison, report a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Drive identical operands onto both default-size instances.
  task automatic drive_big(input logic v, input logic sa, input logic [7:0] ea, input logic [25:0] ma,
                           input logic sb, input logic [7:0] eb, input logic [25:0] mb);
    bus_rne.in_valid = v;  bus_trn.in_valid = v;
    bus_rne.sign_A   = sa; bus_trn.sign_A   = sa;
    bus_rne.exp_A    = ea; bus_trn.exp_A    = ea;
    bus_rne.mantis_A = ma; bus_trn.mantis_A = ma;
    bus_rne.sign_B   = sb; bus_trn.sign_B   = sb;
    bus_rne.exp_B    = eb; bus_trn.exp_B    = eb;
    bus_rne.mantis_B = mb; bus_trn.mantis_B = mb;
  endtask

  task automatic drive_sml(input logic v, input logic sa, input logic [3:0] ea, input logic [3:0] ma,
                           input logic sb, input logic [3:0] eb, input logic [3:0] mb);
    bus_sml.in_valid = v;
    bus_sml.sign_A   = sa;
    bus_sml.exp_A    = ea;
    bus_sml.mantis_A = ma;
    bus_sml.sign_B   = sb;
    bus_sml.exp_B    = eb;
    bus_sml.mantis_B = mb;
  endtask

  // One transaction through the default-size pair; checks latency and fields.
  task automatic run_big(input string tag,
                         input logic sa, input logic [7:0] ea, input logic [25:0] ma,
                         input logic sb, input logic [7:0] eb, input logic [25:0] mb,
                         input logic es, input logic [7:0] ee, input logic [25:0] em_rne,
                         input logic [25:0] em_trn, input logic eo, input logic eu);
    int lat;
    @(negedge clk);
    drive_big(1'b1, sa, ea, ma, sb, eb, mb);
    @(posedge clk);
    #1;
    drive_big(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 8'd0, 26'd0);
    lat = 1;
    while (!bus_rne.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"},   64'(lat), 64'd3);
    check({tag, "_sign"},  64'(bus_rne.sign), 64'(es));
    check({tag, "_exp"},   64'(bus_rne.exp), 64'(ee));
    check({tag, "_man"},   64'(bus_rne.mantis), 64'(em_rne));
    check({tag, "_flags"}, 64'({bus_rne.ovf, bus_rne.unf}), 64'({eo, eu}));
    check({tag, "_trn"},   64'({bus_trn.out_valid, bus_trn.exp, bus_trn.mantis}), 64'({1'b1, ee, em_trn}));
  endtask

  task automatic run_sml(input string tag,
                         input logic sa, input logic [3:0] ea, input logic [3:0] ma,
                         input logic sb, input logic [3:0] eb, input logic [3:0] mb,
                         input logic es, input logic [3:0] ee, input logic [3:0] em,
                         input logic eo, input logic eu);
    int lat;
    @(negedge clk);
    drive_sml(1'b1, sa, ea, ma, sb, eb, mb);
    @(posedge clk);
    #1;
    drive_sml(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    lat = 1;
    while (!bus_sml.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_res"}, 64'({bus_sml.sign, bus_sml.exp, bus_sml.mantis, bus_sml.ovf, bus_sml.unf}),
                         64'({es, ee, em, eo, eu}));
  endtask

  logic [34:0] exp_q [6];
  logic [25:0] bp_mb [6];
  logic [34:0] cur;
  logic        rdy;
  int          n_in;
  int          n_out;
  int          stalls;
  int          stale;

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    drive_big(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 8'd0, 26'd0);
    drive_sml(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    bus_rne.out_ready = 1'b1;
    bus_trn.out_ready = 1'b1;
    bus_sml.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 64'({bus_rne.out_valid, bus_rne.sign, bus_rne.exp, bus_rne.mantis, bus_rne.ovf, bus_rne.unf}), 64'd0);
    check("reset_in_ready", 64'(bus_rne.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Main function and range cases.
    run_big("one_x_one", 1'b0, 8'd127, 26'h2000000, 1'b0, 8'd127, 26'h2000000,
            1'b0, 8'd127, 26'h2000000, 26'h2000000, 1'b0, 1'b0);
    run_big("p15_x_m15", 1'b0, 8'd127, 26'h3000000, 1'b1, 8'd127, 26'h3000000,
            1'b1, 8'd128, 26'h2400000, 26'h2400000, 1'b0, 1'b0);
    run_big("round",     1'b0, 8'd127, 26'h2000003, 1'b0, 8'd127, 26'h2800000,
            1'b0, 8'd127, 26'h2800004, 26'h2800003, 1'b0, 1'b0);
    run_big("ovf",       1'b1, 8'd254, 26'h2000000, 1'b0, 8'd254, 26'h2000000,
            1'b1, 8'hFF, 26'h0, 26'h0, 1'b1, 1'b0);
    run_big("unf",       1'b0, 8'd1, 26'h2000000, 1'b0, 8'd1, 26'h2000000,
            1'b0, 8'd0, 26'h0, 26'h0, 1'b0, 1'b1);
    run_big("zero",      1'b1, 8'd0, 26'h3FFFFFF, 1'b0, 8'd200, 26'h2ABCDEF,
            1'b1, 8'd0, 26'h0, 26'h0, 1'b0, 1'b0);

    // Narrow instance: rounding carry and exponent boundaries.
    run_sml("s_rcarry", 1'b0, 4'd7,  4'd9, 1'b0, 4'd7,  4'd14, 1'b0, 4'd8,  4'd8, 1'b0, 1'b0);
    run_sml("s_e14",    1'b1, 4'd11, 4'd8, 1'b0, 4'd10, 4'd8,  1'b1, 4'd14, 4'd8, 1'b0, 1'b0);
    run_sml("s_e15",    1'b0, 4'd11, 4'd8, 1'b0, 4'd11, 4'd8,  1'b0, 4'hF,  4'd0, 1'b1, 1'b0);
    run_sml("s_e1",     1'b0, 4'd4,  4'd8, 1'b0, 4'd4,  4'd8,  1'b0, 4'd1,  4'd8, 1'b0, 1'b0);
    run_sml("s_e0",     1'b0, 4'd4,  4'd8, 1'b1, 4'd3,  4'd8,  1'b1, 4'd0,  4'd0, 1'b0, 1'b1);
    run_sml("s_rovf",   1'b0, 4'd7,  4'd9, 1'b0, 4'd14, 4'd14, 1'b0, 4'hF,  4'd0, 1'b1, 1'b0);

    // Backpressure: 1.0 * B is exact, so each result equals B.
    for (int k = 0; k < 6; k++) begin
      bp_mb[k] = 26'h2000000 + 26'(26'h111 * (k + 1));
      exp_q[k] = {1'(k % 2), 8'd127, bp_mb[k]};
    end
    n_in = 0; n_out = 0; stalls = 0;
    for (int c = 0; c < 60 && n_out < 6; c++) begin
      @(negedge clk);
      rdy = !(c >= 4 && c <= 8);
      bus_rne.out_ready = rdy;
      bus_trn.out_ready = rdy;
      if (n_in < 6) drive_big(1'b1, 1'b0, 8'd127, 26'h2000000, 1'(n_in % 2), 8'd127, bp_mb[n_in]);
      else          drive_big(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 8'd0, 26'd0);
      #1;
      cur = {bus_rne.sign, bus_rne.exp, bus_rne.mantis};
      if (bus_rne.out_valid && !rdy) begin
        stalls++;
        check("bp_in_ready", 64'(bus_rne.in_ready), 64'd0);
        check("bp_hold", 64'(cur), 64'(exp_q[n_out]));
      end
      if (bus_rne.out_valid && rdy) begin
        check("bp_out", 64'(cur), 64'(exp_q[n_out]));
        n_out++;
      end
      if (bus_rne.in_ready && n_in < 6) n_in++;
    end
    @(negedge clk);
    drive_big(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 8'd0, 26'd0);
    bus_rne.out_ready = 1'b1;
    bus_trn.out_ready = 1'b1;
    #1;
    check("bp_count", 64'(n_out), 64'd6);
    check("bp_stalls", 64'(stalls), 64'd5);
    check("bp_no_dup", 64'(bus_rne.out_valid), 64'd0);

    // Reset with three results in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_big(1'b1, 1'b1, 8'd127, 26'h2000000, 1'b0, 8'd127, 26'h3000000);
    end
    @(negedge clk);
    drive_big(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 8'd0, 26'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out", 64'({bus_rne.out_valid, bus_rne.sign, bus_rne.exp, bus_rne.mantis, bus_rne.ovf, bus_rne.unf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus_rne.out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined floating-point multiplier. Successor to the team's combinational sign/exponent/mantissa multiplier.
- Adds a valid/ready handshake, exponent bias removal and normalisation, selectable rounding, zero handling, and overflow/underflow flags.
- Sits in the FP arithmetic datapath. Operands arrive already unpacked into sign, biased exponent and explicit-leading-one mantissa.

Parameters:
- EXP_W, 8, exponent width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 26, mantissa width including the explicit leading 1 at bit MAN_W-1. Value is 1.f in [1,2).
- ROUND, 1, rounding mode: 0 = truncate, 1 = round-to-nearest-even.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- sign_A, sign_B  in  1 each  operand signs
- exp_A, exp_B  in  EXP_W each  biased exponents; 0 means the operand is zero
- mantis_A, mantis_B  in  MAN_W each  mantissas
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sign  out  1  result sign
- exp  out  EXP_W  result biased exponent
- mantis  out  MAN_W  result mantissa
- ovf  out  1  overflow occurred; result forced to infinity
- unf  out  1  underflow occurred; result flushed to zero

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- On reset: all stage valid bits are 0, out_valid=0, and sign, exp, mantis, ovf, unf are all 0. Reset mid-operation discards every in-flight operand.
- Pipeline has 3 register stages and a fixed latency of 3 cycles from input accept to out_valid, with no stalls.
  - S1 registers the inputs and flags zero operands.
  - S2 forms the 2*MAN_W product and the signed exponent sum eA+eB-BIAS in EXP_W+2 bits.
  - S3 normalises, rounds, and checks range; its register is the output register.
- Handshake:
  - Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational; no combinational path from in_valid to in_ready.
  - A transfer occurs when in_valid & in_ready, or when out_valid & out_ready.
  - When adv=0, every stage holds data and valid. Outputs stay stable while out_valid & ~out_ready.
  - Bubbles propagate as valid=0. Back-to-back throughput is 1 result per cycle.
- Sign: sign_A ^ sign_B in every case, including zero and overflow results.
- Normalisation: let P = mantis_A*mantis_B, 2*MAN_W bits.
  - If P[2*MAN_W-1]=1: M = P[2*MAN_W-1 -: MAN_W], the remainder is the lower MAN_W bits, and the exponent is incremented by 1.
  - Else: M = P[2*MAN_W-2 -: MAN_W] and the remainder is the lower MAN_W-1 bits.
- Rounding when ROUND=1:
  - guard = remainder MSB; sticky = OR of the remaining bits.
  - Increment M when guard & (sticky | M[0]).
  - If the increment carries out (M was all ones), set M = 1000…0 and increment the exponent again.
- Rounding when ROUND=0: drop the remainder.
- Range check is applied after normalisation and rounding, on the signed exponent E:
  - E >= 2^EXP_W-1: exp = all ones, mantis = 0, ovf=1.
  - E <= 0: exp = 0, mantis = 0, unf=1.
  - Otherwise exp = E[EXP_W-1:0], mantis = M, and both flags are 0.
- Zero operand (exp_A==0 or exp_B==0): exp=0, mantis=0, ovf=0, unf=0. This takes priority over the range check.
- ovf and unf are per-result and valid only with out_valid. They are never both 1.

Test Plan:
- 1.0*1.0 (exp 127, mantis 0x2000000 both; defaults) -> 3 cycles later: sign 0, exp 127, mantis 0x2000000, no flags.
- 1.5*-1.5 (mantis 0x3000000, exp 127, sign_B=1) -> sign 1, exp 128, mantis 0x2400000 (value 2.25).
- Rounding: A=0x2000003, B=0x2800000, both exp 127 -> ROUND=1 gives mantis 0x2800004; ROUND=0 gives mantis 0x2800003; exp 127 in both cases.
- Range:
  - exp 254*254 -> exp 0xFF, mantis 0, ovf=1.
  - exp 1*1 -> exp 0, mantis 0, unf=1.
  - exp_A=0 with any B -> zero result, no flags.
- Backpressure: stream 6 operand pairs, hold out_ready=0 for cycles 4–8 -> in_ready=0 while out_valid & ~out_ready, the held output is unchanged, and all 6 results emerge in order with none lost or duplicated.
- Reset with 3 results in flight, asserted for 1 cycle -> out_valid=0 and all outputs 0 the next cycle, and no stale result appears afterwards.
